// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM encodings, default word width and idle/fill constants.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } spi_state_t;

  localparam int unsigned SPI_DATA_W = 8;
  localparam logic        MISO_IDLE  = 1'b0;
  localparam logic [SPI_DATA_W-1:0] FILL_BYTE = 8'h00;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for one asynchronous input, resetting to a chosen idle level.
module spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{rst_val}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave byte engine: synchronised pins, MOSI deserialiser, one-entry MISO buffer.
// Optional SPI_SLAVE_RX_OVR_EN: keep the old byte on overrun and flag a sticky rx_overrun.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_active,
  output logic              frame_abort
`ifdef SPI_SLAVE_RX_OVR_EN
  , output logic            rx_overrun
`endif
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SET_W = $clog2(SYNC_STAGES + 1);

  spi_state_t state, state_nx;

  logic sclk_s, ss_n_s, mosi_s;
  logic sclk_d, ss_n_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic settled;

  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic              byte_done, byte_done_nx;
  logic [DATA_W-1:0] rx_shift, rx_shift_nx;
  logic [DATA_W-1:0] tx_shift, tx_shift_nx;
  logic [DATA_W-1:0] tx_buf, tx_buf_nx;
  logic              tx_ready_nx;
  logic [DATA_W-1:0] rx_data_nx;
  logic              rx_valid_nx;
  logic              abort_nx;
  logic              miso_nx;
  logic              load;
  logic              complete;
  logic [DATA_W-1:0] rx_byte;
`ifdef SPI_SLAVE_RX_OVR_EN
  logic              ovr_nx;
`endif

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .rst_val(1'b0), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .rst(rst), .rst_val(1'b1), .d(ss_n), .q(ss_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .rst_val(1'b0), .d(mosi), .q(mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_rise   = ss_n_s & ~ss_n_d;
  assign ss_fall   = ~ss_n_s & ss_n_d;
  // The synchronisers come out of reset at idle levels, so ss_n is only trusted once flushed.
  assign settled   = (settle_cnt == SET_W'(SYNC_STAGES));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAIT_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_WAIT_IDLE: if (settled && ss_n_s) state_nx = ST_IDLE;
      ST_IDLE:      if (ss_fall)           state_nx = ST_ACTIVE;
      ST_ACTIVE:    if (ss_rise)           state_nx = ST_IDLE;
      default:                             state_nx = ST_WAIT_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    bit_cnt_nx   = bit_cnt;
    byte_done_nx = byte_done;
    rx_shift_nx  = rx_shift;
    tx_shift_nx  = tx_shift;
    tx_buf_nx    = tx_buf;
    tx_ready_nx  = tx_ready;
    rx_data_nx   = rx_data;
    rx_valid_nx  = rx_valid;
    abort_nx     = 1'b0;
    load         = 1'b0;
    complete     = 1'b0;
    rx_byte      = {rx_shift[DATA_W-2:0], mosi_s};
`ifdef SPI_SLAVE_RX_OVR_EN
    ovr_nx       = rx_overrun;
`endif

    if (rx_valid && rx_ready) rx_valid_nx = 1'b0;

    if (state == ST_IDLE && ss_fall) begin
      bit_cnt_nx   = '0;
      byte_done_nx = 1'b0;
      rx_shift_nx  = '0;
      load         = 1'b1;
    end else if (state == ST_ACTIVE) begin
      if (ss_rise) begin
        abort_nx   = (bit_cnt != '0);
        bit_cnt_nx = '0;
      end else if (sclk_rise) begin
        rx_shift_nx = rx_byte;
        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
          bit_cnt_nx   = '0;
          byte_done_nx = 1'b1;
          complete     = 1'b1;
        end else begin
          bit_cnt_nx = bit_cnt + CNT_W'(1);
        end
      end else if (sclk_fall) begin
        if (bit_cnt == '0 && byte_done) begin
          load = 1'b1;
        end else begin
          tx_shift_nx = {tx_shift[DATA_W-2:0], 1'b0};
        end
      end
    end

    // A load consumes the old buffer; a same-cycle write then refills it.
    if (load) begin
      tx_shift_nx = tx_ready ? DATA_W'(FILL_BYTE) : tx_buf;
      tx_ready_nx = 1'b1;
    end
    if (tx_valid && tx_ready) begin
      tx_buf_nx   = tx_data;
      tx_ready_nx = 1'b0;
    end

    if (complete) begin
      if (!rx_valid || rx_ready) begin
        rx_data_nx  = rx_byte;
        rx_valid_nx = 1'b1;
      end else begin
`ifdef SPI_SLAVE_RX_OVR_EN
        ovr_nx      = 1'b1;
`else
        rx_data_nx  = rx_byte;
        rx_valid_nx = 1'b1;
`endif
      end
    end

    miso_nx = (state_nx == ST_ACTIVE) ? tx_shift_nx[DATA_W-1] : MISO_IDLE;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d       <= 1'b0;
      ss_n_d       <= 1'b1;
      settle_cnt   <= '0;
      bit_cnt      <= '0;
      byte_done    <= 1'b0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      tx_buf       <= '0;
      tx_ready     <= 1'b1;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_abort  <= 1'b0;
      frame_active <= 1'b0;
      miso         <= MISO_IDLE;
`ifdef SPI_SLAVE_RX_OVR_EN
      rx_overrun   <= 1'b0;
`endif
    end else begin
      sclk_d       <= sclk_s;
      ss_n_d       <= ss_n_s;
      if (!settled) settle_cnt <= settle_cnt + SET_W'(1);
      bit_cnt      <= bit_cnt_nx;
      byte_done    <= byte_done_nx;
      rx_shift     <= rx_shift_nx;
      tx_shift     <= tx_shift_nx;
      tx_buf       <= tx_buf_nx;
      tx_ready     <= tx_ready_nx;
      rx_data      <= rx_data_nx;
      rx_valid     <= rx_valid_nx;
      frame_abort  <= abort_nx;
      frame_active <= (state_nx == ST_ACTIVE);
      miso         <= miso_nx;
`ifdef SPI_SLAVE_RX_OVR_EN
      rx_overrun   <= ovr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a mode-0 SPI master model plus per-scenario checking tasks.
module tb_spi_slave_rx;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       frame_active;
  logic       frame_abort;
`ifdef SPI_SLAVE_RX_OVR_EN
  logic       rx_overrun;
`endif

  int total = 0;
  int bad = 0;

  int         cyc = 0;
  int         valid_cnt = 0;
  int         abort_cnt = 0;
  int         valid_rise_cyc = 0;
  int         last_rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic       valid_q = 1'b0;

  spi_slave_rx dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_active(frame_active), .frame_abort(frame_abort)
`ifdef SPI_SLAVE_RX_OVR_EN
    , .rx_overrun(rx_overrun)
`endif
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: counts valid cycles and abort pulses, captures data at each rx_valid rise.
  always @(negedge clk) begin
    if (frame_abort) abort_cnt <= abort_cnt + 1;
    if (rx_valid) valid_cnt <= valid_cnt + 1;
    if (rx_valid && !valid_q) begin
      valid_rise_cyc <= cyc;
      rise_data      <= rx_data;
    end
    valid_q <= rx_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit pulse,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (HALF) @(negedge clk);
      mi = {mi[6:0], miso};
      sclk = 1'b1;
      last_rise_cyc = cyc;
      if (pulse && i == nbits - 1) begin
        repeat (2) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_begin;
    ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end;
    ss_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL reset_frame_active got=%b exp=0", frame_active); end
    total++; if (frame_abort !== 1'b0) begin bad++; $display("FAIL reset_frame_abort got=%b exp=0", frame_abort); end
`ifdef SPI_SLAVE_RX_OVR_EN
    total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_rx_overrun got=%b exp=0", rx_overrun); end
`endif
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] mi;
    int v0;
    v0 = valid_cnt;
    frame_begin();
    spi_xfer(8'hA5, 8, 1'b0, mi);
    total++; if (rise_data !== 8'hA5) begin bad++; $display("FAIL basic_rx_data got=%h exp=a5", rise_data); end
    total++; if (valid_rise_cyc - last_rise_cyc != 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3", valid_rise_cyc - last_rise_cyc); end
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL basic_valid_width got=%0d exp=1", valid_cnt - v0); end
    total++; if (mi !== 8'h00) begin bad++; $display("FAIL basic_miso_byte got=%h exp=00", mi); end
    frame_end();
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL basic_frame_end got=%b exp=0", frame_active); end
  endtask

  task automatic test_tx;
    logic [7:0] mi;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL tx_ready_after_write got=%b exp=0", tx_ready); end
    ss_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL tx_ready_before_entry got=%b exp=0", tx_ready); end
    repeat (2) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL tx_ready_after_entry got=%b exp=1", tx_ready); end
    total++; if (frame_active !== 1'b1) begin bad++; $display("FAIL tx_frame_active got=%b exp=1", frame_active); end
    @(negedge clk);
    spi_xfer(8'h5A, 8, 1'b0, mi);
    total++; if (mi !== 8'h3C) begin bad++; $display("FAIL tx_master_capture got=%h exp=3c", mi); end
    total++; if (rise_data !== 8'h5A) begin bad++; $display("FAIL tx_rx_data got=%h exp=5a", rise_data); end
    frame_end();
  endtask

  task automatic test_back_to_back;
    logic [7:0] mi;
    rx_ready = 1'b0;
    frame_begin();
    spi_xfer(8'h55, 8, 1'b0, mi);
    spi_xfer(8'h99, 8, 1'b1, mi);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_rx_valid got=%b exp=1", rx_valid); end
    total++; if (rx_data !== 8'h99) begin bad++; $display("FAIL b2b_rx_data got=%h exp=99", rx_data); end
`ifdef SPI_SLAVE_RX_OVR_EN
    total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL b2b_no_overrun got=%b exp=0", rx_overrun); end
`endif
    frame_end();
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", rx_valid); end
  endtask

  task automatic test_abort;
    logic [7:0] mi;
    int v0, a0;
    v0 = valid_cnt;
    a0 = abort_cnt;
    frame_begin();
    spi_xfer(8'hF0, 5, 1'b0, mi);
    frame_end();
    total++; if (abort_cnt - a0 != 1) begin bad++; $display("FAIL abort_pulses got=%0d exp=1", abort_cnt - a0); end
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL abort_no_valid got=%0d exp=0", valid_cnt - v0); end
    frame_begin();
    spi_xfer(8'hC3, 8, 1'b0, mi);
    frame_end();
    total++; if (rise_data !== 8'hC3) begin bad++; $display("FAIL abort_next_data got=%h exp=c3", rise_data); end
    total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL abort_next_valid got=%0d exp=1", valid_cnt - v0); end
  endtask

  task automatic test_mid_reset;
    logic [7:0] mi;
    int v0, a0;
    frame_begin();
    spi_xfer(8'hE0, 3, 1'b0, mi);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v0 = valid_cnt;
    a0 = abort_cnt;
    spi_xfer(8'hFF, 5, 1'b0, mi);
    total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", valid_cnt - v0); end
    total++; if (frame_active !== 1'b0) begin bad++; $display("FAIL rstmid_inactive got=%b exp=0", frame_active); end
    frame_end();
    total++; if (abort_cnt - a0 != 0) begin bad++; $display("FAIL rstmid_no_abort got=%0d exp=0", abort_cnt - a0); end
    frame_begin();
    spi_xfer(8'h7E, 8, 1'b0, mi);
    frame_end();
    total++; if (rise_data !== 8'h7E) begin bad++; $display("FAIL rstmid_next_data got=%h exp=7e", rise_data); end
  endtask

  task automatic test_overrun;
    logic [7:0] mi;
    rx_ready = 1'b0;
    frame_begin();
    spi_xfer(8'h11, 8, 1'b0, mi);
    spi_xfer(8'h22, 8, 1'b0, mi);
    frame_end();
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_rx_valid got=%b exp=1", rx_valid); end
`ifdef SPI_SLAVE_RX_OVR_EN
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL ovr_rx_data got=%h exp=11", rx_data); end
    total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", rx_overrun); end
`else
    total++; if (rx_data !== 8'h22) begin bad++; $display("FAIL ovr_rx_data got=%h exp=22", rx_data); end
`endif
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b exp=0", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tx();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
